ecc_secded_scrub_memory: RTL and testbench

- Parametrised successor to the team's Hamming-SEC faulty memory.
- Stores DATA_W-bit words as extended-Hamming SECDED codewords: it corrects single-bit errors, detects double-bit errors, and injects transient or persistent faults.
- A background scrubber walks the array and writes back corrected words. Saturating error counters feed the memory-protection status block.

---
 rtl/ecc_secded_pkg.sv | 67 ++++++
 rtl/ecc_secded_scrub_memory_decoder.sv | 55 +++++
 rtl/ecc_secded_scrub_memory.sv | 233 +++++++++++++++++++++++
 tb/tb_ecc_secded_scrub_memory.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ecc_secded_pkg.sv
// Shared definitions for the SECDED scrub memory: derived code sizes, the
// extended-Hamming encoder, the fault-pattern builder and the scrubber states.
package ecc_secded_pkg;

    localparam int MAX_DW = 64;
    localparam int MAX_CW = 72;

    typedef enum logic [2:0] {
        SCRUB_IDLE      = 3'd0,
        SCRUB_WAIT      = 3'd1,
        SCRUB_READ      = 3'd2,
        SCRUB_CHECK     = 3'd3,
        SCRUB_WRITEBACK = 3'd4
    } scrub_state_e;

    function automatic int calc_r(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    function automatic int calc_cw(input int dw);
        return dw + calc_r(dw) + 1;
    endfunction

    // Data fills non-power-of-2 positions LSB-first; bit 0 is overall parity.
    function automatic logic [MAX_CW-1:0] secded_encode(input logic [MAX_DW-1:0] data,
                                                        input int dw);
        logic [MAX_CW-1:0] cw;
        int                cwn;
        int                j;
        int                p;
        logic              par;
        cw  = '0;
        cwn = calc_cw(dw);
        j   = 0;
        for (int pos = 1; pos < MAX_CW; pos++) begin
            if (pos < cwn && (pos & (pos - 1)) != 0) begin
                cw[pos] = data[j];
                j++;
            end
        end
        for (int k = 0; k < 7; k++) begin
            p = 1 << k;
            if (p < cwn) begin
                par = 1'b0;
                for (int pos = 1; pos < MAX_CW; pos++) begin
                    if ((pos & p) != 0 && pos < cwn) par = par ^ cw[pos];
                end
                cw[p] = par;
            end
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [MAX_CW-1:0] fault_pattern(input int a1, input int a2,
                                                        input logic dbl, input int cw);
        logic [MAX_CW-1:0] pat;
        pat = '0;
        if (a1 < cw) pat[a1] = 1'b1;
        if (dbl && a2 < cw) pat[a2] = pat[a2] ^ 1'b1;
        return pat;
    endfunction

endpackage

// File: rtl/ecc_secded_scrub_memory_decoder.sv
// Combinational SECDED decoder: syndrome, overall parity, single-bit correction
// and extraction of the data bits from the Hamming positions.
module ecc_secded_decoder
    import ecc_secded_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [calc_cw(DATA_W)-1:0] cw_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       sec_o,
    output logic                       ded_o,
    output logic [calc_r(DATA_W)-1:0]  syndrome_o
);

    localparam int R  = calc_r(DATA_W);
    localparam int CW = calc_cw(DATA_W);

    logic [R-1:0]  syn_s;
    logic          par_s;
    logic [CW-1:0] fixed_s;
    logic [CW-1:0] src_s;

    // Syndrome, classification and data extraction
    always_comb begin
        int j;
        syn_s   = '0;
        fixed_s = cw_i;
        sec_o   = 1'b0;
        ded_o   = 1'b0;
        data_o  = '0;
        j       = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if (cw_i[pos]) syn_s = syn_s ^ R'(pos);
        end
        par_s = ^cw_i;
        if (par_s && int'(syn_s) < CW) begin
            fixed_s[int'(syn_s)] = ~cw_i[int'(syn_s)];
            sec_o = 1'b1;
        end else if (par_s || syn_s != '0) begin
            ded_o = 1'b1;
        end else begin
            sec_o = 1'b0;
        end
        // On DED the raw bits are returned untouched
        src_s = ded_o ? cw_i : fixed_s;
        for (int pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                data_o[j] = src_s[pos];
                j++;
            end
        end
        syndrome_o = syn_s;
    end

endmodule

// File: rtl/ecc_secded_scrub_memory.sv
// SECDED-protected single-port memory with fault injection, a background
// scrubber that writes back corrected words, and saturating error counters.
module ecc_secded_scrub_memory
    import ecc_secded_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNT_W          = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_W-1:0]                  input_data,
    input  logic [ADDR_W-1:0]                  input_addr,
    input  logic                               wr_en,
    input  logic                               rd_en,
    input  logic                               fault_enable,
    input  logic                               fault_persist,
    input  logic [$clog2(calc_cw(DATA_W))-1:0] fault_addr,
    input  logic                               fault_double,
    input  logic [$clog2(calc_cw(DATA_W))-1:0] fault_addr2,
    input  logic                               scrub_en,
    output logic [DATA_W-1:0]                  output_data,
    output logic                               rd_valid,
    output logic                               single_bit_error_corrected,
    output logic                               double_bit_error_detected,
    output logic [CNT_W-1:0]                   corr_count,
    output logic [CNT_W-1:0]                   uncorr_count,
    output logic                               scrub_busy
);

    localparam int R     = calc_r(DATA_W);
    localparam int CW    = calc_cw(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IW    = $clog2(SCRUB_INTERVAL);
    localparam logic [IW-1:0] LAST_CNT = IW'(SCRUB_INTERVAL - 1);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic a, input logic b);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W + 1)'(a) + (CNT_W + 1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [CW-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    scrub_state_e      state_q, state_d;
    logic [IW-1:0]     cnt_q;
    logic [ADDR_W-1:0] ptr_q, scrub_addr_q;
    logic [CW-1:0]     scrub_cw_q, wb_cw_q, rd_cw_q;
    logic              conflict_q, rd_pend_q, rd_hit_q;
    logic [DATA_W-1:0] data_q;
    logic              rd_valid_q, sec_q, ded_q, busy_q;
    logic [CNT_W-1:0]  corr_q, uncorr_q;

    logic [CW-1:0]     pattern_s, transient_s, cur_word_s, enc_s, dec_cw_s;
    logic              pf_req_s, user_wr_s, user_pf_s, user_rd_s, port_busy_s;
    logic              conflict_now_s, abort_s;
    logic              scrub_fetch_s, scrub_check_s, scrub_wb_s, busy_d;
    logic [DATA_W-1:0] dec_data_s;
    logic              dec_sec_s, dec_ded_s;
    logic [R-1:0]      dec_syn_s;
    logic              user_sec_ev_s, user_ded_ev_s, scrub_sec_ev_s, scrub_ded_ev_s;

    assign pattern_s   = CW'(fault_pattern(int'(fault_addr), int'(fault_addr2), fault_double, CW));
    assign pf_req_s    = fault_enable && fault_persist;
    assign user_wr_s   = wr_en;
    assign user_pf_s   = !wr_en && pf_req_s;
    assign user_rd_s   = !wr_en && !pf_req_s && rd_en;
    assign port_busy_s = wr_en || pf_req_s || rd_en;
    assign transient_s = (fault_enable && !fault_persist) ? pattern_s : '0;
    assign cur_word_s  = mem_q[input_addr];
    assign enc_s       = CW'(secded_encode(MAX_DW'(input_data), DATA_W));

    // A newer user write or persistent fault to the scrubbed entry wins
    assign conflict_now_s = (user_wr_s || user_pf_s) && (input_addr == scrub_addr_q);
    assign abort_s        = conflict_q || conflict_now_s;

    // A pending user read and scrub CHECK never coincide, so one decoder serves both
    assign dec_cw_s = rd_pend_q ? rd_cw_q : scrub_cw_q;

    ecc_secded_decoder #(.DATA_W(DATA_W)) u_dec (
        .cw_i       (dec_cw_s),
        .data_o     (dec_data_s),
        .sec_o      (dec_sec_s),
        .ded_o      (dec_ded_s),
        .syndrome_o (dec_syn_s)
    );

    // Scrub state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= SCRUB_IDLE;
        else     state_q <= state_d;
    end

    // Scrub next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCRUB_IDLE:  state_d = scrub_en ? SCRUB_WAIT : SCRUB_IDLE;
            SCRUB_WAIT: begin
                if (!scrub_en)             state_d = SCRUB_IDLE;
                else if (cnt_q == LAST_CNT) state_d = SCRUB_READ;
                else                       state_d = SCRUB_WAIT;
            end
            SCRUB_READ: begin
                if (port_busy_s)             state_d = SCRUB_READ;
                else if (!valid_q[ptr_q])    state_d = scrub_en ? SCRUB_WAIT : SCRUB_IDLE;
                else                         state_d = SCRUB_CHECK;
            end
            SCRUB_CHECK: begin
                if (dec_sec_s) state_d = SCRUB_WRITEBACK;
                else           state_d = scrub_en ? SCRUB_WAIT : SCRUB_IDLE;
            end
            SCRUB_WRITEBACK: begin
                if (abort_s || !port_busy_s) state_d = scrub_en ? SCRUB_WAIT : SCRUB_IDLE;
                else                         state_d = SCRUB_WRITEBACK;
            end
            default: state_d = SCRUB_IDLE;
        endcase
    end

    // Scrub output decode
    always_comb begin
        scrub_fetch_s = 1'b0;
        scrub_check_s = 1'b0;
        scrub_wb_s    = 1'b0;
        case (state_q)
            SCRUB_READ:      scrub_fetch_s = !port_busy_s;
            SCRUB_CHECK:     scrub_check_s = 1'b1;
            SCRUB_WRITEBACK: scrub_wb_s    = !abort_s && !port_busy_s;
            default:         scrub_fetch_s = 1'b0;
        endcase
        busy_d = (state_d == SCRUB_READ) || (state_d == SCRUB_CHECK) ||
                 (state_d == SCRUB_WRITEBACK);
    end

    // Scrub datapath: interval counter, pointer, fetched and re-encoded words
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            ptr_q        <= '0;
            scrub_addr_q <= '0;
            scrub_cw_q   <= '0;
            wb_cw_q      <= '0;
            conflict_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cnt_q  <= (state_q == SCRUB_WAIT) ? cnt_q + 1'b1 : '0;
            busy_q <= busy_d;
            if (scrub_fetch_s) begin
                scrub_addr_q <= ptr_q;
                scrub_cw_q   <= mem_q[ptr_q];
                conflict_q   <= 1'b0;
                if (!valid_q[ptr_q]) ptr_q <= ptr_q + 1'b1;
            end else if (scrub_check_s) begin
                ptr_q      <= ptr_q + 1'b1;
                wb_cw_q    <= CW'(secded_encode(MAX_DW'(dec_data_s), DATA_W));
                conflict_q <= conflict_now_s;
            end else if (state_q == SCRUB_WRITEBACK) begin
                conflict_q <= abort_s;
            end
        end
    end

    // Array storage: one write per cycle, never touched during reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (user_wr_s)      mem_q[input_addr]   <= enc_s;
            else if (user_pf_s) mem_q[input_addr]   <= cur_word_s ^ pattern_s;
            else if (scrub_wb_s) mem_q[scrub_addr_q] <= wb_cw_q;
        end
    end

    // Entry valid bits
    always_ff @(posedge clk) begin
        if (rst)            valid_q <= '0;
        else if (user_wr_s) valid_q[input_addr] <= 1'b1;
    end

    // User read pipeline: capture the (possibly faulted) word, decode next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_cw_q    <= '0;
            rd_valid_q <= 1'b0;
            data_q     <= '0;
            sec_q      <= 1'b0;
            ded_q      <= 1'b0;
        end else begin
            rd_pend_q  <= user_rd_s;
            rd_valid_q <= rd_pend_q;
            if (user_rd_s) begin
                rd_cw_q  <= cur_word_s ^ transient_s;
                rd_hit_q <= valid_q[input_addr];
            end
            if (rd_pend_q) begin
                data_q <= rd_hit_q ? dec_data_s : '0;
                sec_q  <= rd_hit_q && dec_sec_s;
                ded_q  <= rd_hit_q && dec_ded_s;
            end else begin
                sec_q  <= 1'b0;
                ded_q  <= 1'b0;
            end
        end
    end

    assign user_sec_ev_s  = rd_pend_q && rd_hit_q && dec_sec_s;
    assign user_ded_ev_s  = rd_pend_q && rd_hit_q && dec_ded_s;
    assign scrub_sec_ev_s = scrub_check_s && dec_sec_s;
    assign scrub_ded_ev_s = scrub_check_s && dec_ded_s;

    // Saturating error counters
    always_ff @(posedge clk) begin
        if (rst) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            corr_q   <= sat_add(corr_q, user_sec_ev_s, scrub_sec_ev_s);
            uncorr_q <= sat_add(uncorr_q, user_ded_ev_s, scrub_ded_ev_s);
        end
    end

    assign output_data                = data_q;
    assign rd_valid                   = rd_valid_q;
    assign single_bit_error_corrected = sec_q;
    assign double_bit_error_detected  = ded_q;
    assign corr_count                 = corr_q;
    assign uncorr_count               = uncorr_q;
    assign scrub_busy                 = busy_q;

endmodule

// File: tb/tb_ecc_secded_scrub_memory.sv
// Scoreboard bench: read stimulus pushes expected results, a monitor pops on rd_valid.
module tb_ecc_secded_scrub_memory;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] input_data;
    logic [3:0] input_addr;
    logic       wr_en, rd_en, fault_enable, fault_persist, fault_double, scrub_en;
    logic [3:0] fault_addr, fault_addr2;
    logic [7:0] output_data;
    logic       rd_valid, sec, ded, scrub_busy;
    logic [7:0] corr_count, uncorr_count;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    ecc_secded_scrub_memory #(
        .DATA_W(8), .ADDR_W(4), .SCRUB_INTERVAL(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .input_data(input_data), .input_addr(input_addr),
        .wr_en(wr_en), .rd_en(rd_en), .fault_enable(fault_enable),
        .fault_persist(fault_persist), .fault_addr(fault_addr),
        .fault_double(fault_double), .fault_addr2(fault_addr2), .scrub_en(scrub_en),
        .output_data(output_data), .rd_valid(rd_valid),
        .single_bit_error_corrected(sec), .double_bit_error_detected(ded),
        .corr_count(corr_count), .uncorr_count(uncorr_count), .scrub_busy(scrub_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compare every presented read result against the scoreboard
    always @(posedge clk) begin
        #1;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 data=%0h expected no read", output_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data", {24'd0, output_data}, {24'd0, e.d});
                check("rd_sec", {31'd0, sec}, {31'd0, e.s});
                check("rd_ded", {31'd0, ded}, {31'd0, e.e});
            end
        end
    end

    // All stimulus tasks start and end on a negative edge
    task automatic do_write(input int addr, input logic [7:0] d);
        input_addr = 4'(addr); input_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_pfault(input int addr, input int b);
        input_addr = 4'(addr); fault_addr = 4'(b); fault_double = 1'b0;
        fault_enable = 1'b1; fault_persist = 1'b1;
        @(negedge clk);
        fault_enable = 1'b0; fault_persist = 1'b0;
    endtask

    task automatic do_read(input int addr, input logic fe, input int fa, input logic fd,
                           input int fa2, input logic [7:0] ed, input logic es, input logic ee);
        exp_t e;
        input_addr = 4'(addr); fault_enable = fe; fault_persist = 1'b0;
        fault_addr = 4'(fa); fault_double = fd; fault_addr2 = 4'(fa2); rd_en = 1'b1;
        e.d = ed; e.s = es; e.e = ee;
        exp_q.push_back(e);
        @(negedge clk);
        rd_en = 1'b0; fault_enable = 1'b0; fault_double = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_corr(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (corr_count == 8'(target)) break;
        end
        check(name, {24'd0, corr_count}, target);
    endtask

    initial begin
        rst = 1'b1; input_data = '0; input_addr = '0; wr_en = 1'b0; rd_en = 1'b0;
        fault_enable = 1'b0; fault_persist = 1'b0; fault_double = 1'b0;
        fault_addr = '0; fault_addr2 = '0; scrub_en = 1'b0;
        settle(3);
        check("reset_rd_valid", {31'd0, rd_valid}, 0);
        check("reset_data", {24'd0, output_data}, 0);
        check("reset_corr", {24'd0, corr_count}, 0);
        check("reset_uncorr", {24'd0, uncorr_count}, 0);
        check("reset_busy", {31'd0, scrub_busy}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Unwritten entry, then a clean round trip
        do_read(0, 1'b0, 0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        do_write(3, 8'hA5);
        do_read(3, 1'b0, 0, 1'b0, 0, 8'hA5, 1'b0, 1'b0);
        settle(2);
        check("t1_corr", {24'd0, corr_count}, 0);
        check("t1_uncorr", {24'd0, uncorr_count}, 0);

        // Transient single-bit fault on every codeword bit
        do_write(1, 8'h3C);
        for (int b = 0; b < 13; b++) do_read(1, 1'b1, b, 1'b0, 0, 8'h3C, 1'b1, 1'b0);
        settle(2);
        check("t2_corr", {24'd0, corr_count}, 13);

        // Double fault on data positions 5 (d1) and 9 (d4): raw bits come back
        do_write(2, 8'hFF);
        do_read(2, 1'b1, 5, 1'b1, 9, 8'hED, 1'b0, 1'b1);
        do_read(2, 1'b1, 7, 1'b1, 7, 8'hFF, 1'b0, 1'b0);
        settle(2);
        check("t3_uncorr", {24'd0, uncorr_count}, 1);
        check("t3_corr", {24'd0, corr_count}, 13);

        // Scrubber repairs a persistent fault on addr 4
        do_write(4, 8'h5A);
        do_pfault(4, 6);
        scrub_en = 1'b1;
        wait_corr(14, 300, "t4_scrub_sec");
        check("t4_busy_wb", {31'd0, scrub_busy}, 1);
        scrub_en = 1'b0;
        settle(4);
        check("t4_busy_idle", {31'd0, scrub_busy}, 0);
        do_read(4, 1'b0, 0, 1'b0, 0, 8'h5A, 1'b0, 1'b0);
        settle(2);
        check("t4_corr", {24'd0, corr_count}, 14);

        // A user write during a pending writeback must win
        do_write(5, 8'h11);
        do_pfault(5, 3);
        scrub_en = 1'b1;
        wait_corr(15, 300, "t5_scrub_sec");
        scrub_en = 1'b0;
        do_write(5, 8'hC3);
        settle(4);
        do_read(5, 1'b0, 0, 1'b0, 0, 8'hC3, 1'b0, 1'b0);
        settle(2);
        check("t5_corr", {24'd0, corr_count}, 15);

        // Reset while in WRITEBACK
        do_write(6, 8'h77);
        do_pfault(6, 2);
        scrub_en = 1'b1;
        wait_corr(16, 300, "t6_scrub_sec");
        rst = 1'b1; scrub_en = 1'b0;
        settle(2);
        check("t6_rst_corr", {24'd0, corr_count}, 0);
        check("t6_rst_uncorr", {24'd0, uncorr_count}, 0);
        check("t6_rst_busy", {31'd0, scrub_busy}, 0);
        check("t6_rst_rd_valid", {31'd0, rd_valid}, 0);
        rst = 1'b0;
        @(negedge clk);
        do_read(6, 1'b0, 0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        settle(3);
        check("t6_idle_busy", {31'd0, scrub_busy}, 0);

        // Counter saturation
        do_write(7, 8'h42);
        for (int i = 0; i < 300; i++) do_read(7, 1'b1, i % 13, 1'b0, 0, 8'h42, 1'b1, 1'b0);
        settle(3);
        check("t6_sat_corr", {24'd0, corr_count}, 255);
        check("t6_sat_uncorr", {24'd0, uncorr_count}, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
